// File: rtl/branch_resolve_unit_pkg.sv
// rtl/branch_resolve_unit_pkg.sv - shared types and constants for the branch resolve unit
//
// Contents:
//   XLEN_DEF    default datapath/PC width
//   bru_state_e FSM encoding (IDLE, REDIRECT, SQUASH)
//   br_type_e   resolved branch kind after priority selection
//   br_type_sel priority encoder, jr > jmp > br
package branch_resolve_unit_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        SQUASH   = 2'd2
    } bru_state_e;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_COND = 2'd1,
        BR_JMP  = 2'd2,
        BR_JR   = 2'd3
    } br_type_e;

    function automatic br_type_e br_type_sel(input logic is_br, input logic is_jmp,
                                             input logic is_jr);
        br_type_e t;
        if (is_jr) begin
            t = BR_JR;
        end else if (is_jmp) begin
            t = BR_JMP;
        end else if (is_br) begin
            t = BR_COND;
        end else begin
            t = BR_NONE;
        end
        return t;
    endfunction

endpackage

// File: rtl/bru_target_calc.sv
// rtl/bru_target_calc.sv - combinational redirect target and jr alignment check
//
// Ports:
//   br_type   resolved branch kind (priority already applied)
//   ex_pc     PC of the EX instruction
//   ex_offset signed word offset for PC-relative branches and jumps
//   ex_rs_val register value used as the jr target
//   target    redirect address
//   misalign  jr target had nonzero low bits (target is still forced aligned)
module bru_target_calc
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  br_type_e          br_type,
    input  logic [XLEN-1:0]   ex_pc,
    input  logic [XLEN-1:0]   ex_offset,
    input  logic [XLEN-1:0]   ex_rs_val,
    output logic [XLEN-1:0]   target,
    output logic              misalign
);

    always_comb begin
        target   = '0;
        misalign = 1'b0;
        if (br_type == BR_JR) begin
            target   = {ex_rs_val[XLEN-1:2], 2'b00};
            misalign = |ex_rs_val[1:0];
        end else begin
            // Word offset scaled to bytes; overflow wraps modulo 2^XLEN by design.
            target = ex_pc + (ex_offset << 2);
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - resolves taken branches, issues fetch redirect and squash
//
// Optional feature macro: BRU_PERF_CNT_EN (adds br_total / br_taken counters)
//
// Ports:
//   clk, rst              clock (rising edge), synchronous active-high reset
//   ex_valid              EX slot holds a real instruction
//   ex_is_br/jmp/jr       branch kind flags (priority jr > jmp > br)
//   cond_y                condition-unit result for conditional branches
//   ex_pc/ex_offset       PC-relative target operands
//   ex_rs_val             jump-register target
//   stall                 global pipeline stall
//   redirect_valid/pc     registered fetch redirect
//   flush_if_id/id_ex     squash of the wrong-path pipeline registers
//   misalign              sticky flag: a jr target had nonzero low bits
//   br_total/br_taken     conditional-branch counters (BRU_PERF_CNT_EN only)
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN          = XLEN_DEF,
    parameter int SQUASH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              ex_is_br,
    input  logic              ex_is_jmp,
    input  logic              ex_is_jr,
    input  logic              cond_y,
    input  logic [XLEN-1:0]   ex_pc,
    input  logic [XLEN-1:0]   ex_offset,
    input  logic [XLEN-1:0]   ex_rs_val,
    input  logic              stall,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc,
    output logic              flush_if_id,
    output logic              flush_id_ex,
`ifdef BRU_PERF_CNT_EN
    output logic              misalign,
    output logic [31:0]       br_total,
    output logic [31:0]       br_taken
`else
    output logic              misalign
`endif
);

    // The issue edge itself counts as the first flush cycle.
    localparam logic [2:0] SQ_INIT = 3'(SQUASH_CYCLES - 1);

    bru_state_e        state_q, state_d;
    logic [2:0]        count_q, count_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
    logic              flush_q, flush_d;
    logic              misalign_q, misalign_d;

    br_type_e          br_type;
    logic              taken;
    logic [XLEN-1:0]   tgt;
    logic              tgt_misalign;

    assign br_type = br_type_sel(ex_is_br, ex_is_jmp, ex_is_jr);
    assign taken   = ex_valid & (ex_is_jr | ex_is_jmp | (ex_is_br & cond_y));

    bru_target_calc #(.XLEN(XLEN)) u_target_calc (
        .br_type   (br_type),
        .ex_pc     (ex_pc),
        .ex_offset (ex_offset),
        .ex_rs_val (ex_rs_val),
        .target    (tgt),
        .misalign  (tgt_misalign)
    );

    always_comb begin
        state_d          = state_q;
        count_d          = count_q;
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;
        flush_d          = flush_q;
        misalign_d       = misalign_q;
        case (state_q)
            IDLE: begin
                // A stalled taken branch simply waits and is re-evaluated next cycle.
                if (taken && !stall) begin
                    state_d          = REDIRECT;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = tgt;
                    flush_d          = 1'b1;
                    count_d          = SQ_INIT;
                    if (tgt_misalign) begin
                        misalign_d = 1'b1;
                    end
                end
            end
            REDIRECT: begin
                // The acceptance cycle is also an unstalled flush cycle, so it consumes a count.
                if (!stall) begin
                    redirect_valid_d = 1'b0;
                    if (count_q == 3'd0) begin
                        flush_d = 1'b0;
                        state_d = IDLE;
                    end else begin
                        count_d = count_q - 3'd1;
                        state_d = SQUASH;
                    end
                end
            end
            SQUASH: begin
                if (!stall) begin
                    if (count_q == 3'd0) begin
                        flush_d = 1'b0;
                        state_d = IDLE;
                    end else begin
                        count_d = count_q - 3'd1;
                    end
                end
            end
            default: begin
                state_d          = IDLE;
                redirect_valid_d = 1'b0;
                flush_d          = 1'b0;
                count_d          = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            count_q          <= 3'd0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            flush_q          <= 1'b0;
            misalign_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            count_q          <= count_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            flush_q          <= flush_d;
            misalign_q       <= misalign_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush_if_id    = flush_q;
    assign flush_id_ex    = flush_q;
    assign misalign       = misalign_q;

`ifdef BRU_PERF_CNT_EN
    logic [31:0] br_total_q, br_total_d;
    logic [31:0] br_taken_q, br_taken_d;
    logic        br_count_en;

    // Only branches seen while the unit is idle are on the correct path.
    assign br_count_en = (state_q == IDLE) && ex_valid && ex_is_br && !stall;

    always_comb begin
        br_total_d = br_total_q;
        br_taken_d = br_taken_q;
        if (br_count_en && (br_total_q != 32'hFFFF_FFFF)) begin
            br_total_d = br_total_q + 32'd1;
        end
        if (br_count_en && cond_y && (br_taken_q != 32'hFFFF_FFFF)) begin
            br_taken_d = br_taken_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            br_total_q <= 32'd0;
            br_taken_q <= 32'd0;
        end else begin
            br_total_q <= br_total_d;
            br_taken_q <= br_taken_d;
        end
    end

    assign br_total = br_total_q;
    assign br_taken = br_taken_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed scoreboard bench for branch_resolve_unit
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_is_br, ex_is_jmp, ex_is_jr, cond_y, stall;
    logic [31:0] ex_pc, ex_offset, ex_rs_val;
    logic        redirect_valid, flush_if_id, flush_id_ex, misalign;
    logic [31:0] redirect_pc;
`ifdef BRU_PERF_CNT_EN
    logic [31:0] br_total, br_taken;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic        rv;
        logic [31:0] pc;
        logic        fl;
        logic        mis;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    branch_resolve_unit #(.XLEN(32), .SQUASH_CYCLES(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_is_br       (ex_is_br),
        .ex_is_jmp      (ex_is_jmp),
        .ex_is_jr       (ex_is_jr),
        .cond_y         (cond_y),
        .ex_pc          (ex_pc),
        .ex_offset      (ex_offset),
        .ex_rs_val      (ex_rs_val),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush_if_id    (flush_if_id),
        .flush_id_ex    (flush_id_ex),
`ifdef BRU_PERF_CNT_EN
        .misalign       (misalign),
        .br_total       (br_total),
        .br_taken       (br_taken)
`else
        .misalign       (misalign)
`endif
    );

    task automatic set_in(input logic v, input logic br, input logic jmp, input logic jr,
                          input logic c, input logic [31:0] pc, input logic [31:0] off,
                          input logic [31:0] rs);
        ex_valid  = v;
        ex_is_br  = br;
        ex_is_jmp = jmp;
        ex_is_jr  = jr;
        cond_y    = c;
        ex_pc     = pc;
        ex_offset = off;
        ex_rs_val = rs;
    endtask

    task automatic clear_in();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    endtask

    // Push the expected post-edge outputs, clock once, then pop and compare.
    task automatic step(input string tag, input logic st, input logic rv,
                        input logic [31:0] pc, input logic fl, input logic mis);
        exp_t e;
        stall = st;
        e.tag = tag;
        e.rv  = rv;
        e.pc  = pc;
        e.fl  = fl;
        e.mis = mis;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        assert (redirect_valid === e.rv) else begin
            failures++;
            $error("FAIL %s redirect_valid observed=%0b expected=%0b", e.tag, redirect_valid, e.rv);
        end
        checks++;
        assert (redirect_pc === e.pc) else begin
            failures++;
            $error("FAIL %s redirect_pc observed=%h expected=%h", e.tag, redirect_pc, e.pc);
        end
        checks++;
        assert (flush_if_id === e.fl) else begin
            failures++;
            $error("FAIL %s flush_if_id observed=%0b expected=%0b", e.tag, flush_if_id, e.fl);
        end
        checks++;
        assert (flush_id_ex === e.fl) else begin
            failures++;
            $error("FAIL %s flush_id_ex observed=%0b expected=%0b", e.tag, flush_id_ex, e.fl);
        end
        checks++;
        assert (misalign === e.mis) else begin
            failures++;
            $error("FAIL %s misalign observed=%0b expected=%0b", e.tag, misalign, e.mis);
        end
    endtask

    initial begin
        rst   = 1'b1;
        stall = 1'b0;
        clear_in();
        step("reset", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        step("idle", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        // Taken conditional branch: 0x100 + 3*4
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'd3, 32'h0);
        step("br_issue", 1'b0, 1'b1, 32'h10C, 1'b1, 1'b0);
        clear_in();
        step("br_squash", 1'b0, 1'b0, 32'h10C, 1'b1, 1'b0);
        step("br_done", 1'b0, 1'b0, 32'h10C, 1'b0, 1'b0);
        step("br_idle", 1'b0, 1'b0, 32'h10C, 1'b0, 1'b0);

        // Not-taken branch
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'd3, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step("not_taken", 1'b0, 1'b0, 32'h10C, 1'b0, 1'b0);
        end

        // Taken flags but ex_valid low
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h500, 32'd1, 32'h0);
        step("invalid", 1'b0, 1'b0, 32'h10C, 1'b0, 1'b0);

        // Wrap-around jump
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'd2, 32'h0);
        step("wrap_issue", 1'b0, 1'b1, 32'h4, 1'b1, 1'b0);
        clear_in();
        step("wrap_squash", 1'b0, 1'b0, 32'h4, 1'b1, 1'b0);
        step("wrap_done", 1'b0, 1'b0, 32'h4, 1'b0, 1'b0);

        // Taken while stalled in IDLE waits, then issues
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'd3, 32'h0);
        step("idle_stall", 1'b1, 1'b0, 32'h4, 1'b0, 1'b0);
        step("stall_issue", 1'b0, 1'b1, 32'h10C, 1'b1, 1'b0);
        clear_in();
        for (int i = 0; i < 3; i++) begin
            step("redir_hold", 1'b1, 1'b1, 32'h10C, 1'b1, 1'b0);
        end
        step("stall_squash", 1'b0, 1'b0, 32'h10C, 1'b1, 1'b0);
        step("stall_done", 1'b0, 1'b0, 32'h10C, 1'b0, 1'b0);

        // Wrong-path taken branch during REDIRECT/SQUASH is ignored
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1000, 32'd1, 32'h0);
        step("wp_issue", 1'b0, 1'b1, 32'h1004, 1'b1, 1'b0);
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'd3, 32'h0);
        step("wp_redirect", 1'b0, 1'b0, 32'h1004, 1'b1, 1'b0);
        step("wp_squash", 1'b0, 1'b0, 32'h1004, 1'b0, 1'b0);
        clear_in();

        // Misaligned jr, jmp flag also set to exercise jr priority
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h100, 32'd3, 32'h203);
        step("jr_issue", 1'b0, 1'b1, 32'h200, 1'b1, 1'b1);
        clear_in();
        step("jr_squash", 1'b0, 1'b0, 32'h200, 1'b1, 1'b1);
        step("jr_done", 1'b0, 1'b0, 32'h200, 1'b0, 1'b1);
        step("jr_sticky", 1'b0, 1'b0, 32'h200, 1'b0, 1'b1);

        // Reset during REDIRECT
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'd4, 32'h0);
        step("rst_issue", 1'b0, 1'b1, 32'h50, 1'b1, 1'b1);
        clear_in();
        rst = 1'b1;
        step("rst_redirect", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        step("rst_after", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- EX/MEM-boundary stage directly downstream of the branch condition evaluator.
- Consumes the 1-bit condition result plus EX-stage branch metadata; decides taken/not-taken and computes the redirect target.
- Drives the fetch-PC redirect and squashes wrong-path instructions in IF/ID and ID/EX for a fixed number of cycles.
- Sequential: registered redirect, squash counter, and a 3-state FSM.

Parameters:
- XLEN, 32, datapath/PC width
- SQUASH_CYCLES, 2, cycles flush_* stay high after a redirect issues (1..7)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  EX slot holds a real instruction
- ex_is_br  in  1  conditional branch (uses cond_y)
- ex_is_jmp  in  1  unconditional PC-relative jump
- ex_is_jr  in  1  jump-register (target = ex_rs_val)
- cond_y  in  1  condition-unit result (1 = condition met)
- ex_pc  in  XLEN  PC of EX instruction
- ex_offset  in  XLEN  signed word offset
- ex_rs_val  in  XLEN  register target for jr
- stall  in  1  global pipeline stall from hazard unit
- redirect_valid  out  1  fetch must load redirect_pc
- redirect_pc  out  XLEN  new fetch address
- flush_if_id  out  1  squash IF/ID register
- flush_id_ex  out  1  squash ID/EX register
- misalign  out  1  jr target low 2 bits nonzero (sticky until rst)

Behaviour:
- Reset values: redirect_valid=0, redirect_pc=0, flush_*=0, misalign=0, FSM=IDLE, squash count=0.
- taken = ex_valid & (ex_is_jr | ex_is_jmp | (ex_is_br & cond_y)).
- Priority when several type flags are set: jr > jmp > br.
- Target:
  - jr: {ex_rs_val[XLEN-1:2], 2'b00}.
  - Otherwise: ex_pc + (ex_offset << 2), modulo 2^XLEN; wrap-around is legal and silent.
- FSM states: IDLE, REDIRECT, SQUASH.
- IDLE:
  - taken & !stall -> REDIRECT at next edge. That same edge registers redirect_pc, sets redirect_valid=1, flush_*=1, and count=SQUASH_CYCLES-1.
  - taken & stall -> no action; re-evaluated next cycle.
- REDIRECT:
  - redirect_valid and flush_* stay high while stall=1.
  - First cycle with stall=0 is the acceptance cycle. At the following edge redirect_valid drops. If count==0, flush_* drop and FSM goes to IDLE; otherwise FSM goes to SQUASH.
- SQUASH:
  - flush_*=1, redirect_valid=0.
  - Count decrements on each edge with stall=0. At count==0 with stall=0, flush_* drop and FSM goes to IDLE.
- Latency: taken-branch detection to redirect_valid is 1 cycle. Total flush duration is SQUASH_CYCLES unstalled cycles.
- In REDIRECT/SQUASH, ex_valid/taken inputs are ignored (wrong path); no new redirect is issued.
- Not-taken, or ex_valid=0: no output change.
- misalign:
  - Set on jr issue when ex_rs_val[1:0]!=0; the redirect still issues with the forced-aligned target.
  - Cleared only by rst.
- rst asserted in any state: all outputs return to reset values at that edge; an in-flight redirect is dropped.

Optional Feature:
- Macro BRU_PERF_CNT_EN.
- Defined:
  - Adds outputs br_total[31:0], br_taken[31:0].
  - br_total increments on every edge where FSM==IDLE, ex_valid & ex_is_br, and stall=0. br_taken additionally requires cond_y=1.
  - Both saturate at 32'hFFFF_FFFF and clear on rst.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, REDIRECT=2'd1, SQUASH=2'd2), XLEN default, branch-type constants.
- One sub-module, bru_target_calc: purely combinational target/misalign computation, instantiated once.

Test Plan:
- Taken branch:
  - Stimulus: ex_pc=0x100, ex_offset=3, ex_is_br=1, cond_y=1, stall=0.
  - Response: next cycle redirect_valid=1, redirect_pc=0x10C, flush_*=1. Flush high exactly 2 cycles, then IDLE.
- Not-taken branch: same stimulus with cond_y=0 -> redirect_valid and flush_* stay 0 for all cycles.
- Wrap-around: ex_pc=0xFFFF_FFFC, ex_offset=2, ex_is_jmp=1 -> redirect_pc=0x0000_0004.
- Stall during REDIRECT: stall=1 for 3 cycles after issue -> redirect_valid and flush held 4 cycles total, then flush 1 more cycle, then 0.
- Jump-register misaligned: ex_is_jr=1, ex_rs_val=0x203 -> redirect_pc=0x200, misalign=1 until rst.
- Wrong-path and reset:
  - Stimulus: a second taken branch during SQUASH.
  - Response: it is ignored, redirect_pc unchanged.
  - Stimulus: rst during REDIRECT.
  - Response: all outputs 0 next edge.
